ssp_min_select: RTL and testbench

- Upstream frontier stage of the SSSP accelerator.
- Scans the DRAM distance region (32 distances of 32 bits per 1024-bit word, node id → word dist_offset+(id>>5), lane id[4:0]).
- Selects the unvisited node with the smallest finite tentative distance and hands it to the relaxation stage as dnow/dnow_id.
- Tracks visited nodes in an internal bitmap and flags completion when no reachable unvisited node remains.

---
 rtl/ssp_pkg.sv | 20 ++
 rtl/lane_min32.sv | 33 +++
 rtl/ssp_min_select.sv | 129 ++++++++++++
 tb/tb_ssp_min_select.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// ssp_pkg: constants, lane helper and scan states shared by the SSSP frontier and relaxation stages
package ssp_pkg;
  localparam int MAX_NODES = 1024;
  localparam int DATA_W = 1024;
  localparam int LANE_W = 32;
  localparam int LANES = DATA_W / LANE_W;
  localparam logic [LANE_W-1:0] INF = '1;
  typedef enum logic [2:0] {
    IDLE,
    SCAN_INIT,
    ISSUE,
    RWAIT0,
    RWAIT,
    REDUCE,
    FINISH
  } scan_state_t;
  function automatic logic [LANE_W-1:0] lane_of(input logic [DATA_W-1:0] d, input int i);
    return d[i*LANE_W +: LANE_W];
  endfunction
endpackage

// File: rtl/lane_min32.sv
// lane_min32: masked minimum over 32 lanes via a 5-level compare tree, ties to the lower lane
module lane_min32
  import ssp_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [LANES-1:0]  mask,
  output logic [LANE_W-1:0] min_val,
  output logic [4:0]        min_idx,
  output logic              any_valid
);
  // heap layout: leaves at LANES-1.., children of k are 2k+1 (lower lanes) and 2k+2
  logic [LANE_W-1:0] v [0:2*LANES-2];
  logic [4:0]        x [0:2*LANES-2];
  logic              e [0:2*LANES-2];
  logic              sel;
  always_comb begin
    sel = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      v[LANES-1+i] = lane_of(data, i);
      x[LANES-1+i] = 5'(i);
      e[LANES-1+i] = mask[i];
    end
    for (int k = LANES - 2; k >= 0; k--) begin
      sel  = e[2*k+1] && (!e[2*k+2] || v[2*k+1] <= v[2*k+2]);
      v[k] = sel ? v[2*k+1] : v[2*k+2];
      x[k] = sel ? x[2*k+1] : x[2*k+2];
      e[k] = e[2*k+1] || e[2*k+2];
    end
  end
  assign min_val   = v[0];
  assign min_idx   = x[0];
  assign any_valid = e[0];
endmodule

// File: rtl/ssp_min_select.sv
// ssp_min_select: scans the DRAM distance region and hands the nearest unvisited node to relaxation
module ssp_min_select
  import ssp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       num_nodes,
  input  logic [31:0]       dist_offset,
  input  logic              next_req,
  input  logic              rready,
  output logic              renable,
  output logic [31:0]       raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic [31:0]       dnow,
  output logic [31:0]       dnow_id,
  output logic              dnow_valid,
  output logic              all_done,
  output logic              busy
);
  scan_state_t          state;
  logic [10:0]          vcnt;
  logic [31:0]          offset;
  logic [4:0]           word;
  logic [LANE_W-1:0]    best;
  logic [9:0]           best_id;
  logic [MAX_NODES-1:0] visited;
  logic [DATA_W-1:0]    hold;
  logic                 drain;
  logic [LANES-1:0]     mask;
  logic [LANE_W-1:0]    m_val;
  logic [4:0]           m_idx;
  logic                 m_any;
  logic [5:0]           nwords;
  logic                 last;
  always_comb begin
    mask = '0;
    for (int i = 0; i < LANES; i++)
      mask[i] = ({1'b0, word, 5'(i)} < vcnt) && !visited[{word, 5'(i)}] && (lane_of(hold, i) != INF);
  end
  assign nwords = 6'((vcnt + 11'd31) >> 5);
  assign last   = ({1'b0, word} + 6'd1) == nwords;
  lane_min32 u_min (
    .data(hold),
    .mask(mask),
    .min_val(m_val),
    .min_idx(m_idx),
    .any_valid(m_any)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      renable    <= 1'b0;
      raddr      <= '0;
      dnow       <= '0;
      dnow_id    <= '0;
      dnow_valid <= 1'b0;
      all_done   <= 1'b0;
      busy       <= 1'b0;
      visited    <= '0;
      vcnt       <= '0;
      offset     <= '0;
      word       <= '0;
      best       <= INF;
      best_id    <= '0;
      hold       <= '0;
      drain      <= 1'b0;
    end else begin
      renable    <= 1'b0;
      dnow_valid <= 1'b0;
      if (start) begin
        // an issued read must still be absorbed before the restarted scan may issue its own
        visited  <= '0;
        vcnt     <= (num_nodes > 32'(MAX_NODES)) ? 11'(MAX_NODES) : num_nodes[10:0];
        offset   <= dist_offset;
        all_done <= 1'b0;
        busy     <= 1'b1;
        drain    <= state == RWAIT0 || (state == RWAIT && !rready);
        state    <= state == RWAIT0 ? RWAIT : (state == RWAIT && !rready) ? RWAIT : SCAN_INIT;
      end else begin
        case (state)
          IDLE: if (next_req && !all_done) begin
            busy  <= 1'b1;
            state <= SCAN_INIT;
          end
          SCAN_INIT: begin
            word    <= '0;
            best    <= INF;
            best_id <= '0;
            busy    <= 1'b1;
            state   <= vcnt == '0 ? FINISH : ISSUE;
          end
          ISSUE: if (rready) begin
            renable <= 1'b1;
            raddr   <= offset + 32'(word);
            state   <= RWAIT0;
          end
          RWAIT0: state <= RWAIT;
          RWAIT: if (rready) begin
            drain <= 1'b0;
            hold  <= drain ? hold : rdata;
            state <= drain ? SCAN_INIT : REDUCE;
          end
          REDUCE: begin
            if (m_any && m_val < best) begin
              best    <= m_val;
              best_id <= {word, m_idx};
            end
            word  <= last ? word : word + 5'd1;
            state <= last ? FINISH : ISSUE;
          end
          FINISH: begin
            if (best != INF) begin
              visited[best_id] <= 1'b1;
              dnow             <= best;
              dnow_id          <= {22'd0, best_id};
              dnow_valid       <= 1'b1;
            end else begin
              all_done <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ssp_min_select.sv
// tb_ssp_min_select: directed vectors against ssp_min_select with a simple DRAM read model
module tb_ssp_min_select;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   num_nodes = '0;
  logic [31:0]   dist_offset = '0;
  logic          next_req = 1'b0;
  logic          rdy = 1'b1;
  logic          renable;
  logic [31:0]   raddr;
  logic [1023:0] rdata;
  logic [31:0]   dnow;
  logic [31:0]   dnow_id;
  logic          dnow_valid;
  logic          all_done;
  logic          busy;
  logic [1023:0] mem [0:63];
  logic [31:0]   la = '0;
  logic [31:0]   addr_log [0:255];
  int            rcnt = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  localparam logic [31:0] INF = 32'hFFFF_FFFF;
  ssp_min_select dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_nodes(num_nodes),
    .dist_offset(dist_offset),
    .next_req(next_req),
    .rready(rdy),
    .renable(renable),
    .raddr(raddr),
    .rdata(rdata),
    .dnow(dnow),
    .dnow_id(dnow_id),
    .dnow_valid(dnow_valid),
    .all_done(all_done),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (renable) begin
      la <= raddr;
      addr_log[rcnt[7:0]] <= raddr;
      rcnt <= rcnt + 1;
    end
  end
  assign rdata = mem[la[5:0]];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic fill_inf;
    for (int w = 0; w < 64; w++) mem[w] = '1;
  endtask
  task automatic set_lane(input int w, input int l, input logic [31:0] val);
    mem[w][32*l +: 32] = val;
  endtask
  task automatic pulse_start(input logic [31:0] v, input logic [31:0] off);
    num_nodes = v;
    dist_offset = off;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic pulse_next;
    next_req = 1'b1;
    @(negedge clk);
    next_req = 1'b0;
  endtask
  task automatic wait_result(output logic got, output logic [31:0] d, output logic [31:0] id);
    got = 1'b0;
    d = '0;
    id = '0;
    for (int c = 0; c < 2000; c++) begin
      if (dnow_valid) begin
        got = 1'b1;
        d = dnow;
        id = dnow_id;
        return;
      end
      if (all_done) return;
      @(negedge clk);
    end
    check("result_timeout", 64'd0, 64'd1);
  endtask
  task automatic wait_ren(input logic [31:0] addr);
    for (int c = 0; c < 500; c++) begin
      if (renable && raddr == addr) return;
      @(negedge clk);
    end
    check("renable_timeout", 64'd0, 64'd1);
  endtask
  logic        got;
  logic [31:0] d, id;
  int          base;
  int          bad;
  initial begin
    fill_inf();
    repeat (2) @(negedge clk);
    check("rst_renable", renable, 0);
    check("rst_outs", {raddr, dnow}, 0);
    check("rst_flags", {dnow_id, dnow_valid, all_done, busy}, 0);
    reset = 1'b0;
    @(negedge clk);
    // 1: V=4, pick order by distance then all_done
    fill_inf();
    for (int l = 4; l < 32; l++) set_lane(0, l, 32'd1);
    set_lane(0, 0, 32'd0);
    set_lane(0, 1, 32'd5);
    set_lane(0, 3, 32'd3);
    base = rcnt;
    pulse_start(32'd4, 32'h100);
    wait_result(got, d, id);
    check("t1_p1", {31'd0, got, d, id}, {32'd1, 32'd0, 32'd0});
    check("t1_busy_after", busy, 0);
    pulse_next();
    wait_result(got, d, id);
    check("t1_p2", {31'd0, got, d, id}, {32'd1, 32'd3, 32'd3});
    pulse_next();
    wait_result(got, d, id);
    check("t1_p3", {31'd0, got, d, id}, {32'd1, 32'd5, 32'd1});
    pulse_next();
    wait_result(got, d, id);
    check("t1_done", {got, all_done}, 2'b01);
    check("t1_hold", {dnow, dnow_id}, {32'd5, 32'd1});
    check("t1_reads", rcnt - base, 4);
    pulse_next();
    repeat (10) @(negedge clk);
    check("t1_ignored", {busy, all_done}, 2'b01);
    check("t1_ignored_reads", rcnt - base, 4);
    // 2: tie across words resolves to lowest id
    fill_inf();
    set_lane(16, 7, 32'd9);
    set_lane(17, 2, 32'd9);
    base = rcnt;
    pulse_start(32'd40, 32'h210);
    wait_result(got, d, id);
    check("t2_pick", {31'd0, got, d, id}, {32'd1, 32'd9, 32'd7});
    check("t2_reads", rcnt - base, 2);
    check("t2_addr0", addr_log[base[7:0]], 32'h210);
    check("t2_addr1", addr_log[8'(base + 1)], 32'h211);
    // 3: lanes beyond V are ignored
    fill_inf();
    for (int l = 1; l < 32; l++) set_lane(33, l, 32'd0);
    base = rcnt;
    pulse_start(32'd33, 32'h20);
    wait_result(got, d, id);
    check("t3_done", {got, all_done}, 2'b01);
    check("t3_reads", rcnt - base, 2);
    // 4: read data stalled for 20 cycles
    fill_inf();
    set_lane(0, 0, 32'd0);
    set_lane(0, 1, 32'd5);
    set_lane(0, 3, 32'd3);
    base = rcnt;
    pulse_start(32'd4, 32'h100);
    wait_ren(32'h100);
    rdy = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (renable || dnow_valid || !busy) bad++;
    end
    check("t4_stall", bad, 0);
    rdy = 1'b1;
    wait_result(got, d, id);
    check("t4_pick", {31'd0, got, d, id}, {32'd1, 32'd0, 32'd0});
    check("t4_reads", rcnt - base, 1);
    // 5: restart during the word-3 read drains it and clears visited
    fill_inf();
    set_lane(40, 5, 32'd50);
    set_lane(43, 0, 32'd10);
    pulse_start(32'd128, 32'h28);
    wait_result(got, d, id);
    check("t5_p1", {31'd0, got, d, id}, {32'd1, 32'd10, 32'd96});
    pulse_next();
    wait_result(got, d, id);
    check("t5_p2", {31'd0, got, d, id}, {32'd1, 32'd50, 32'd5});
    pulse_next();
    wait_ren(32'h2B);
    rdy = 1'b0;
    @(negedge clk);
    base = rcnt;
    pulse_start(32'd128, 32'h28);
    rdy = 1'b1;
    wait_result(got, d, id);
    check("t5_restart", {31'd0, got, d, id}, {32'd1, 32'd10, 32'd96});
    check("t5_reads", rcnt - base, 4);
    check("t5_first_addr", addr_log[base[7:0]], 32'h28);
    // 6: empty graph, then reset mid-scan
    base = rcnt;
    pulse_start(32'd0, 32'h100);
    repeat (2) @(negedge clk);
    check("t6_v0_done", {busy, all_done}, 2'b01);
    check("t6_v0_reads", rcnt - base, 0);
    pulse_start(32'd128, 32'h28);
    wait_ren(32'h29);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_rst_outs", {raddr, dnow}, 0);
    check("t6_rst_flags", {dnow_id, renable, dnow_valid, all_done, busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (dnow_valid || busy || renable) bad++;
    end
    check("t6_after_rst", bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
